// File: rtl/clock_tick_scheduler.sv
// Stopwatch tick scheduler: divides clk into one-cycle enables and sequences RUN/PAUSED/ADJ.
// Optional monitor outputs (tick total, illegal-mode flag) under CLK_TICK_SCHED_MONITOR_EN.

module clock_tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tc
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal count: the edge on which a full period of enabled edges completes.
  assign tc = en && (cnt == LAST);
endmodule

// state  | meaning
// RUN    | normal tick drives the counter enable
// PAUSED | no count ticks; adjust=0 with pause_flag=1
// ADJ    | adjust tick drives the enable, blink active
module clock_tick_scheduler #(
  parameter int CLK_HZ     = 100000000,
  parameter int NORMAL_HZ  = 1,
  parameter int ADJ_HZ     = 2,
  parameter int BLINK_HZ   = 4,
  parameter int REFRESH_HZ = 500
) (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic       in_pause,
  input  logic       in_adjust,
  input  logic       in_select,
  output logic       out_count_tick,
  output logic       out_adj_min,
  output logic       out_blink,
  output logic       out_refresh,
  output logic [1:0] out_mode
`ifdef CLK_TICK_SCHED_MONITOR_EN
  ,
  output logic [15:0] out_tick_total,
  output logic        out_mode_err
`endif
);
  localparam int DIV_NORMAL  = CLK_HZ / NORMAL_HZ;
  localparam int DIV_ADJ     = CLK_HZ / ADJ_HZ;
  localparam int DIV_BLINK   = CLK_HZ / BLINK_HZ;
  localparam int DIV_REFRESH = CLK_HZ / REFRESH_HZ;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    PAUSED = 2'b01,
    ADJ    = 2'b10
  } mode_t;

  mode_t mode_q, mode_nxt;
  logic  pause_flag, pause_nxt;
  logic  count_tick_nxt, blink_nxt, adj_min_nxt;

  logic [1:0] pause_sync, adjust_sync, select_sync;
  logic       pause_d;
  logic       pause_edge;
  logic       normal_tc, adj_tc, blink_tc, refresh_tc;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      pause_sync  <= 2'b00;
      adjust_sync <= 2'b00;
      select_sync <= 2'b00;
      pause_d     <= 1'b0;
    end else begin
      pause_sync  <= {pause_sync[0], in_pause};
      adjust_sync <= {adjust_sync[0], in_adjust};
      select_sync <= {select_sync[0], in_select};
      pause_d     <= pause_sync[1];
    end
  end

  assign pause_edge = pause_sync[1] && !pause_d;

  clock_tick_divider #(.DIV(DIV_NORMAL)) u_normal_div (
    .clk(in_clock), .rst_n(in_reset_n), .en(mode_q == RUN), .tc(normal_tc)
  );
  clock_tick_divider #(.DIV(DIV_ADJ)) u_adj_div (
    .clk(in_clock), .rst_n(in_reset_n), .en(mode_q == ADJ), .tc(adj_tc)
  );
  clock_tick_divider #(.DIV(DIV_BLINK)) u_blink_div (
    .clk(in_clock), .rst_n(in_reset_n), .en(mode_q == ADJ), .tc(blink_tc)
  );
  clock_tick_divider #(.DIV(DIV_REFRESH)) u_refresh_div (
    .clk(in_clock), .rst_n(in_reset_n), .en(1'b1), .tc(refresh_tc)
  );

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      mode_q         <= RUN;
      pause_flag     <= 1'b0;
      out_count_tick <= 1'b0;
      out_blink      <= 1'b0;
      out_adj_min    <= 1'b0;
      out_refresh    <= 1'b0;
    end else begin
      mode_q         <= mode_nxt;
      pause_flag     <= pause_nxt;
      out_count_tick <= count_tick_nxt;
      out_blink      <= blink_nxt;
      out_adj_min    <= adj_min_nxt;
      out_refresh    <= refresh_tc;
    end
  end

  always_comb begin
    pause_nxt      = pause_flag ^ pause_edge;
    mode_nxt       = RUN;
    count_tick_nxt = 1'b0;
    blink_nxt      = 1'b0;
    adj_min_nxt    = 1'b0;

    // The pause flag keeps toggling inside ADJ and takes effect on exit.
    if (adjust_sync[1]) begin
      mode_nxt = ADJ;
    end else if (pause_nxt) begin
      mode_nxt = PAUSED;
    end

    // A tick is only issued when the mode it belongs to holds across the edge.
    if (mode_q == RUN && mode_nxt == RUN) begin
      count_tick_nxt = normal_tc;
    end else if (mode_q == ADJ && mode_nxt == ADJ) begin
      count_tick_nxt = adj_tc;
    end

    if (mode_nxt == ADJ) begin
      blink_nxt   = out_blink ^ blink_tc;
      adj_min_nxt = select_sync[1];
    end
  end

  assign out_mode = mode_q;

`ifdef CLK_TICK_SCHED_MONITOR_EN
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_tick_total <= 16'd0;
      out_mode_err   <= 1'b0;
    end else begin
      out_tick_total <= out_tick_total + 16'(out_count_tick);
      out_mode_err   <= out_mode_err | (out_mode == 2'b11);
    end
  end
`endif
endmodule

// File: tb/tb_clock_tick_scheduler.sv
// Self-checking bench for clock_tick_scheduler: directed scenarios plus random input
// activity, compared every cycle against a timestamp-based reference model.

module tb_clock_tick_scheduler;
  localparam int CLK_HZ     = 40;
  localparam int NORMAL_HZ  = 1;
  localparam int ADJ_HZ     = 2;
  localparam int BLINK_HZ   = 4;
  localparam int REFRESH_HZ = 10;
  localparam int DIV_N = CLK_HZ / NORMAL_HZ;
  localparam int DIV_A = CLK_HZ / ADJ_HZ;
  localparam int DIV_B = CLK_HZ / BLINK_HZ;
  localparam int DIV_R = CLK_HZ / REFRESH_HZ;
  localparam int HMAX  = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pause = 1'b0, adjust = 1'b0, select = 1'b0;
  logic count_tick, adj_min, blink, refresh;
  logic [1:0] mode;
`ifdef CLK_TICK_SCHED_MONITOR_EN
  logic [15:0] tick_total;
  logic        mode_err;
`endif

  clock_tick_scheduler #(
    .CLK_HZ(CLK_HZ), .NORMAL_HZ(NORMAL_HZ), .ADJ_HZ(ADJ_HZ),
    .BLINK_HZ(BLINK_HZ), .REFRESH_HZ(REFRESH_HZ)
  ) dut (
    .in_clock(clk),
    .in_reset_n(rst_n),
    .in_pause(pause),
    .in_adjust(adjust),
    .in_select(select),
    .out_count_tick(count_tick),
    .out_adj_min(adj_min),
    .out_blink(blink),
    .out_refresh(refresh),
    .out_mode(mode)
`ifdef CLK_TICK_SCHED_MONITOR_EN
    ,
    .out_tick_total(tick_total),
    .out_mode_err(mode_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_ticks = 0;

  // Reference model: inputs sampled at edge k are recorded in hist[k] = {pause, adjust, select}.
  logic [2:0] hist [0:HMAX-1];
  int cyc;
  bit pf;
  int m_prev, enter, model_total;
  bit e_tick, e_blink, e_ref, e_min;
  int e_mode;

  function automatic logic [2:0] h(input int idx);
    return (idx < 1) ? 3'b000 : hist[idx];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; pf = 1'b0; m_prev = 0; enter = 0; model_total = 0;
    e_tick = 1'b0; e_blink = 1'b0; e_ref = 1'b0; e_min = 1'b0; e_mode = 0;
    for (int i = 0; i < HMAX; i++) hist[i] = 3'b000;
  endtask

  // Mode from inputs seen two edges earlier; ticks from time elapsed since the mode was entered.
  task automatic model_step();
    logic [2:0] a2, a3;
    int len;
    a2 = h(cyc - 2);
    a3 = h(cyc - 3);
    if (a2[2] && !a3[2]) pf = !pf;
    e_mode = a2[1] ? 2 : (pf ? 1 : 0);
    if (e_mode != m_prev) begin
      enter  = cyc;
      m_prev = e_mode;
    end
    len = cyc - enter + 1;
    e_tick  = (e_mode == 0 && len > 1 && (len - 1) % DIV_N == 0) ||
              (e_mode == 2 && len > 1 && (len - 1) % DIV_A == 0);
    e_blink = (e_mode == 2) && (((len - 1) / DIV_B) % 2 == 1);
    e_ref   = (cyc > 0) && (cyc % DIV_R == 0);
    e_min   = (e_mode == 2) && a2[0];
    model_total += int'(e_tick);
  endtask

  task automatic check_all();
    chk("count_tick", 16'(count_tick), 16'(e_tick));
    chk("blink", 16'(blink), 16'(e_blink));
    chk("refresh", 16'(refresh), 16'(e_ref));
    chk("adj_min", 16'(adj_min), 16'(e_min));
    chk("mode", 16'(mode), 16'(e_mode));
`ifdef CLK_TICK_SCHED_MONITOR_EN
    chk("tick_total", tick_total, 16'(model_total));
    chk("mode_err", 16'(mode_err), 16'd0);
`endif
  endtask

  task automatic run(input int n);
    repeat (n) begin
      hist[cyc + 1] = {pause, adjust, select};
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      if (count_tick === 1'b1) dut_ticks++;
      check_all();
    end
  endtask

  task automatic pause_pulse(input int width);
    pause = 1'b1;
    run(width);
    pause = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Free running from reset with inputs low.
    run(39);
    chk("tick_c39", 16'(count_tick), 16'd0);
    run(1);
    chk("tick_c40", 16'(count_tick), 16'd1);
    run(1);
    chk("tick_c41", 16'(count_tick), 16'd0);
    run(159);
    chk("ticks_200", 16'(dut_ticks), 16'd5);

    // Pause and resume.
    pause_pulse(3);
    run(5);
    chk("mode_paused", 16'(mode), 16'd1);
    run(100);
    pause_pulse(3);
    run(5);
    chk("mode_resumed", 16'(mode), 16'd0);
    run(60);

    // Adjust with minutes selected, then back to RUN.
    adjust = 1'b1;
    select = 1'b1;
    run(3);
    chk("mode_adj", 16'(mode), 16'd2);
    chk("adj_min_on", 16'(adj_min), 16'd1);
    run(80);
    adjust = 1'b0;
    run(3);
    chk("run_after_adj", 16'(mode), 16'd0);
    chk("blink_cleared", 16'(blink), 16'd0);
    chk("adj_min_cleared", 16'(adj_min), 16'd0);
    run(20);

    // Pause edge inside ADJ takes effect on exit.
    select = 1'b0;
    adjust = 1'b1;
    run(10);
    pause_pulse(2);
    run(30);
    adjust = 1'b0;
    run(3);
    chk("paused_after_adj", 16'(mode), 16'd1);
    pause_pulse(2);
    run(5);
    chk("run_after_unpause", 16'(mode), 16'd0);
    run(45);

    // Pause edge coincident with adjust rise.
    pause  = 1'b1;
    adjust = 1'b1;
    run(3);
    chk("coincident_adj", 16'(mode), 16'd2);
    pause = 1'b0;
    run(25);
    adjust = 1'b0;
    run(3);
    chk("coincident_flag", 16'(mode), 16'd1);
    pause_pulse(2);
    run(10);

    // Random input activity.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(29, 0) == 0) pause = ~pause;
      if ($urandom_range(199, 0) == 0) adjust = ~adjust;
      if ($urandom_range(49, 0) == 0) select = ~select;
      run(1);
    end

    // Asynchronous reset in the middle of ADJ.
    pause  = 1'b0;
    select = 1'b1;
    adjust = 1'b1;
    run(30);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_count_tick", 16'(count_tick), 16'd0);
    chk("rst_blink", 16'(blink), 16'd0);
    chk("rst_refresh", 16'(refresh), 16'd0);
    chk("rst_adj_min", 16'(adj_min), 16'd0);
    chk("rst_mode", 16'(mode), 16'd0);
    pause = 1'b0; adjust = 1'b0; select = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check_all();
    run(39);
    chk("post_rst_c39", 16'(count_tick), 16'd0);
    run(1);
    chk("post_rst_c40", 16'(count_tick), 16'd1);
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
